// File: rtl/kernel_window_if.sv
// Column-in / window-out stream bundle for kernel_window.
// master drives columns and consumes windows; slave is the window generator.
interface kernel_window_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int BLOCK_WIDTH  = 3,
  parameter int BLOCK_HEIGHT = 3,
  parameter int COL_WIDTH    = 6
);
  logic                                              frame_start;
  logic [DATA_WIDTH*BLOCK_HEIGHT-1:0]                in_pixels;
  logic                                              in_valid;
  logic                                              in_ready;
  logic [DATA_WIDTH*BLOCK_WIDTH*BLOCK_HEIGHT-1:0]    out_pixels;
  logic                                              out_valid;
  logic                                              out_ready;
  logic [COL_WIDTH-1:0]                              out_col;
  logic                                              out_last;

  modport master (
    output frame_start, in_pixels, in_valid, out_ready,
    input  in_ready, out_pixels, out_valid, out_col, out_last
  );

  modport slave (
    input  frame_start, in_pixels, in_valid, out_ready,
    output in_ready, out_pixels, out_valid, out_col, out_last
  );
endinterface

// File: rtl/kernel_window.sv
// Sliding BLOCK_WIDTH x BLOCK_HEIGHT window generator with stride and end-of-line flag.
// Define KERNEL_WINDOW_EDGE_REPLICATE_EN to replicate the column-0 pixels across the window (left border).
module kernel_window #(
  parameter int BLOCK_WIDTH  = 3,
  parameter int BLOCK_HEIGHT = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 64,
  parameter int STRIDE       = 1,
  parameter int COL_WIDTH    = $clog2(IMAGE_WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  kernel_window_if.slave  bus
);

  localparam int SW       = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int WIN_W    = DATA_WIDTH * BLOCK_WIDTH * BLOCK_HEIGHT;
  localparam int LAST_MIN = (IMAGE_WIDTH > STRIDE) ? IMAGE_WIDTH - STRIDE : 0;

  localparam logic [COL_WIDTH-1:0] COL_MAX      = COL_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [COL_WIDTH-1:0] COL_LAST_MIN = COL_WIDTH'(LAST_MIN);
  localparam logic [SW-1:0]        STRIDE_MAX   = SW'(STRIDE - 1);
`ifdef KERNEL_WINDOW_EDGE_REPLICATE_EN
  localparam logic [COL_WIDTH-1:0] COL_FIRST    = '0;
`else
  localparam logic [COL_WIDTH-1:0] COL_FIRST    = COL_WIDTH'(BLOCK_WIDTH - 1);
`endif

  logic [WIN_W-1:0]     r_window;
  logic [COL_WIDTH-1:0] r_col;
  logic [SW-1:0]        r_stride;
  logic                 r_out_valid;
  logic [COL_WIDTH-1:0] r_out_col;
  logic                 r_out_last;

  logic                 w_in_ready;
  logic                 w_accept;
  logic [SW-1:0]        w_stride_cur;
  logic [SW-1:0]        w_stride_next;
  logic [COL_WIDTH-1:0] w_col_next;
  logic                 w_eligible;
  logic                 w_last;
  logic [WIN_W-1:0]     w_window_next;

  assign w_in_ready = !bus.frame_start && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  // Stride phase restarts at the first column that can complete a window.
  assign w_stride_cur  = (r_col == COL_FIRST) ? '0 : r_stride;
  assign w_stride_next = (w_stride_cur == STRIDE_MAX) ? '0 : w_stride_cur + SW'(1);
  assign w_col_next    = (r_col == COL_MAX) ? '0 : r_col + COL_WIDTH'(1);

`ifdef KERNEL_WINDOW_EDGE_REPLICATE_EN
  assign w_eligible = (w_stride_cur == '0);
`else
  assign w_eligible = (r_col >= COL_FIRST) && (w_stride_cur == '0);
`endif
  // The next eligible column is STRIDE away; it is last if that falls off the line.
  assign w_last = w_eligible && (r_col >= COL_LAST_MIN);

  always_comb begin
    w_window_next = r_window;
    for (int r = 0; r < BLOCK_HEIGHT; r++) begin
      for (int c = 0; c < BLOCK_WIDTH - 1; c++) begin
        w_window_next[(r*BLOCK_WIDTH+c)*DATA_WIDTH +: DATA_WIDTH] =
          r_window[(r*BLOCK_WIDTH+c+1)*DATA_WIDTH +: DATA_WIDTH];
      end
      w_window_next[(r*BLOCK_WIDTH+BLOCK_WIDTH-1)*DATA_WIDTH +: DATA_WIDTH] =
        bus.in_pixels[r*DATA_WIDTH +: DATA_WIDTH];
`ifdef KERNEL_WINDOW_EDGE_REPLICATE_EN
      if (r_col == '0) begin
        for (int c = 0; c < BLOCK_WIDTH; c++) begin
          w_window_next[(r*BLOCK_WIDTH+c)*DATA_WIDTH +: DATA_WIDTH] =
            bus.in_pixels[r*DATA_WIDTH +: DATA_WIDTH];
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_window    <= '0;
      r_col       <= '0;
      r_stride    <= '0;
      r_out_valid <= 1'b0;
      r_out_col   <= '0;
      r_out_last  <= 1'b0;
    end else if (bus.frame_start) begin
      r_col       <= '0;
      r_stride    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_window    <= w_window_next;
      r_col       <= w_col_next;
      r_stride    <= w_stride_next;
      r_out_valid <= w_eligible;
      r_out_col   <= r_col;
      r_out_last  <= w_last;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_pixels = r_window;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_col    = r_out_col;
  assign bus.out_last   = r_out_last;

endmodule

// File: tb/tb_kernel_window.sv
// Bench for kernel_window: STRIDE=1 and STRIDE=2 instances on an 8-column line, checked against
// a line-history reference model under directed and randomized stimulus.
module tb_kernel_window;
  localparam int DW = 8;
  localparam int BW = 3;
  localparam int BH = 3;
  localparam int IW = 8;
  localparam int CW = 3;
  localparam int PW = DW * BH;
  localparam int WW = DW * BW * BH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fs = 1'b0;
  logic iv = 1'b0;
  logic ordy = 1'b1;
  logic [PW-1:0] px = '0;

  always #5 clk = ~clk;

  kernel_window_if #(.DATA_WIDTH(DW), .BLOCK_WIDTH(BW), .BLOCK_HEIGHT(BH), .COL_WIDTH(CW)) if0 ();
  kernel_window_if #(.DATA_WIDTH(DW), .BLOCK_WIDTH(BW), .BLOCK_HEIGHT(BH), .COL_WIDTH(CW)) if1 ();

  assign if0.frame_start = fs;
  assign if0.in_pixels   = px;
  assign if0.in_valid    = iv;
  assign if0.out_ready   = ordy;
  assign if1.frame_start = fs;
  assign if1.in_pixels   = px;
  assign if1.in_valid    = iv;
  assign if1.out_ready   = ordy;

  kernel_window #(.BLOCK_WIDTH(BW), .BLOCK_HEIGHT(BH), .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .STRIDE(1))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  kernel_window #(.BLOCK_WIDTH(BW), .BLOCK_HEIGHT(BH), .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .STRIDE(2))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-instance history of the columns accepted in the current line.
  int            m_stride [2] = '{1, 2};
  int            m_pos    [2];
  bit            m_v      [2];
  logic [CW-1:0] m_col    [2];
  bit            m_last   [2];
  logic [WW-1:0] m_win    [2];
  logic [PW-1:0] hist     [2][IW];

  task automatic chk(input string tag, input int d, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  function automatic bit elig(input int d, input int pos);
`ifdef KERNEL_WINDOW_EDGE_REPLICATE_EN
    return (pos % m_stride[d]) == 0;
`else
    return (pos >= BW - 1) && (((pos - (BW - 1)) % m_stride[d]) == 0);
`endif
  endfunction

  function automatic bit is_last(input int d, input int pos);
    if (!elig(d, pos)) return 1'b0;
    for (int j = pos + 1; j < IW; j++) if (elig(d, j)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [WW-1:0] build(input int d, input int pos);
    logic [WW-1:0] w;
    int idx;
    w = '0;
    for (int c = 0; c < BW; c++) begin
      idx = pos - (BW - 1 - c);
      if (idx < 0) idx = 0;
      for (int r = 0; r < BH; r++) w[(r*BW+c)*DW +: DW] = hist[d][idx][r*DW +: DW];
    end
    return w;
  endfunction

  function automatic logic [WW-1:0] mkwin(input int a, input int b, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < BH; r++) begin
      w[(r*BW+0)*DW +: DW] = DW'(a);
      w[(r*BW+1)*DW +: DW] = DW'(b);
      w[(r*BW+2)*DW +: DW] = DW'(c);
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pos[d] = 0; m_v[d] = 1'b0; m_col[d] = '0; m_last[d] = 1'b0; m_win[d] = '0;
    end
  endtask

  task automatic model_update(input int d);
    bit rdy;
    rdy = !fs && (!m_v[d] || ordy);
    if (fs) begin
      m_pos[d] = 0;
      m_v[d]   = 1'b0;
    end else if (iv && rdy) begin
      hist[d][m_pos[d]] = px;
      m_v[d]    = elig(d, m_pos[d]);
      m_col[d]  = CW'(m_pos[d]);
      m_last[d] = is_last(d, m_pos[d]);
      if (m_v[d]) m_win[d] = build(d, m_pos[d]);
      m_pos[d]  = (m_pos[d] + 1) % IW;
    end else if (ordy) begin
      m_v[d] = 1'b0;
    end
  endtask

  task automatic check_dut(input int d);
    logic rdy, v, last;
    logic [WW-1:0] pix;
    logic [CW-1:0] col;
    if (d == 0) begin
      rdy = if0.in_ready; v = if0.out_valid; pix = if0.out_pixels; col = if0.out_col; last = if0.out_last;
    end else begin
      rdy = if1.in_ready; v = if1.out_valid; pix = if1.out_pixels; col = if1.out_col; last = if1.out_last;
    end
    chk("in_ready", d, 128'(rdy), 128'(!fs && (!m_v[d] || ordy)));
    chk("out_valid", d, 128'(v), 128'(m_v[d]));
    if (m_v[d]) begin
      chk("out_pixels", d, 128'(pix), 128'(m_win[d]));
      chk("out_col", d, 128'(col), 128'(m_col[d]));
      chk("out_last", d, 128'(last), 128'(m_last[d]));
    end
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", 0, 128'(if0.in_ready), 128'(1));
    chk("rst_in_ready", 1, 128'(if1.in_ready), 128'(1));
    chk("rst_out_valid", 0, 128'(if0.out_valid), 128'(0));
    chk("rst_out_valid", 1, 128'(if1.out_valid), 128'(0));
    chk("rst_out_pixels", 0, 128'(if0.out_pixels), 128'(0));
    chk("rst_out_pixels", 1, 128'(if1.out_pixels), 128'(0));
    chk("rst_out_col", 0, 128'(if0.out_col), 128'(0));
    chk("rst_out_last", 0, 128'(if0.out_last), 128'(0));
  endtask

  // Inputs are set just after a rising edge; outputs are checked 1 ns later, then the model advances.
  task automatic cycle();
    #1;
    check_dut(0);
    check_dut(1);
    model_update(0);
    model_update(1);
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int val);
    fs = 1'b0; iv = 1'b1; px = {BH{DW'(val)}};
    cycle();
  endtask

  initial begin
    model_reset();
    #1;
    chk_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Line 1: pixel value equals column index.
    for (int k = 0; k < IW; k++) begin
      feed(k);
`ifndef KERNEL_WINDOW_EDGE_REPLICATE_EN
      if (k == 2) begin
        chk("first_win_pix", 0, 128'(if0.out_pixels), 128'(mkwin(0, 1, 2)));
        chk("first_win_col", 0, 128'(if0.out_col), 128'(2));
      end
      if (k == 6) chk("s2_last_at_6", 1, 128'(if1.out_last), 128'(1));
`endif
    end
`ifndef KERNEL_WINDOW_EDGE_REPLICATE_EN
    chk("last_win_pix", 0, 128'(if0.out_pixels), 128'(mkwin(5, 6, 7)));
    chk("last_win_col", 0, 128'(if0.out_col), 128'(7));
    chk("last_win_flag", 0, 128'(if0.out_last), 128'(1));
    chk("s2_no_win_at_7", 1, 128'(if1.out_valid), 128'(0));
`endif

    // Line 2 back to back.
    for (int k = 0; k < IW; k++) begin
      feed(k);
`ifndef KERNEL_WINDOW_EDGE_REPLICATE_EN
      if (k == 1) chk("line2_no_mix", 0, 128'(if0.out_valid), 128'(0));
      if (k == 2) chk("line2_first_pix", 0, 128'(if0.out_pixels), 128'(mkwin(0, 1, 2)));
`endif
    end

    // Line 3 with a 5-cycle stall after the first window.
    for (int k = 0; k < 3; k++) feed(k);
    ordy = 1'b0;
    px = {BH{DW'(3)}};
    for (int k = 0; k < 5; k++) cycle();
`ifndef KERNEL_WINDOW_EDGE_REPLICATE_EN
    chk("stall_hold_pix", 0, 128'(if0.out_pixels), 128'(mkwin(0, 1, 2)));
    chk("stall_in_ready", 0, 128'(if0.in_ready), 128'(0));
`endif
    ordy = 1'b1;
    cycle();
`ifndef KERNEL_WINDOW_EDGE_REPLICATE_EN
    chk("after_stall_pix", 0, 128'(if0.out_pixels), 128'(mkwin(1, 2, 3)));
`endif
    for (int k = 4; k < IW; k++) feed(k);

    // frame_start at column 4, then a fresh line starting with value 10.
    for (int k = 0; k < 4; k++) feed(k);
    fs = 1'b1; iv = 1'b1; px = {BH{DW'(99)}};
    cycle();
    for (int k = 10; k < 13; k++) feed(k);
`ifndef KERNEL_WINDOW_EDGE_REPLICATE_EN
    chk("fs_win_pix", 0, 128'(if0.out_pixels), 128'(mkwin(10, 11, 12)));
    chk("fs_win_col", 0, 128'(if0.out_col), 128'(2));
`endif

    // Randomized traffic with backpressure and occasional frame_start.
    for (int k = 0; k < 600; k++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fs   = ($urandom_range(0, 63) == 0);
      px   = PW'($urandom);
      cycle();
    end

    // Reset mid-line at column 5.
    ordy = 1'b1;
    fs = 1'b1; iv = 1'b0;
    cycle();
    for (int k = 0; k < 5; k++) feed(20 + k);
    iv = 1'b0; fs = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < IW; k++) feed(40 + k);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/kernel_window.md
# kernel_window

Streaming sliding-window generator for the HOG pipeline.
- Accepts one pixel column (BLOCK_HEIGHT pixels, one per image row) per handshake and shifts it into a BLOCK_WIDTH × BLOCK_HEIGHT window register.
- Emits the full window downstream with a single valid/ready pair, so the per-row handshakes are replaced by one handshake.
- Tracks the column position within a line and suppresses windows that straddle a line boundary.
- Supports a configurable horizontal stride and flags the last window of each line.
- Sits between the line buffers and the gradient/histogram stages.

## Interface
Parameters:
- BLOCK_WIDTH, 3: window columns; must be ≥ 2.
- BLOCK_HEIGHT, 3: window rows; must be ≥ 1.
- DATA_WIDTH, 8: bits per pixel.
- IMAGE_WIDTH, 64: columns per line; must be ≥ BLOCK_WIDTH.
- STRIDE, 1: horizontal distance between emitted windows, in columns; must be ≥ 1.
- COL_WIDTH, $clog2(IMAGE_WIDTH): derived width of the column index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- frame_start  in  1  synchronous clear of line position; one-cycle pulse.
- in_pixels  in  DATA_WIDTH*BLOCK_HEIGHT  column; row r at [r*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  1  column valid.
- in_ready  out  1  column accepted when in_valid && in_ready.
- out_pixels  out  DATA_WIDTH*BLOCK_WIDTH*BLOCK_HEIGHT  window; pixel (r,c) at [(r*BLOCK_WIDTH+c)*DATA_WIDTH +: DATA_WIDTH]; c=0 oldest, c=BLOCK_WIDTH-1 newest.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts the window.
- out_col  out  COL_WIDTH  line column of the newest column in the window.
- out_last  out  1  window is the last one emitted for the line.

## Operation
- State:
  - window register;
  - col counter, range 0..IMAGE_WIDTH-1;
  - stride counter, range 0..STRIDE-1;
  - output valid flag.
- in_ready = !frame_start && (!out_valid || out_ready).
- On accept:
  - window shifts left by one column and in_pixels enters c=BLOCK_WIDTH-1;
  - col increments and wraps IMAGE_WIDTH-1 → 0.
- Emit-eligible column: col ≥ BLOCK_WIDTH-1 and the stride counter is 0.
  - The stride counter resets to 0 at col = BLOCK_WIDTH-1.
  - Within the line, the stride counter increments modulo STRIDE on each accept from that point on.
- On accept, out_valid ← emit-eligible. out_col ← accepted col. out_last ← emit-eligible and no later column in the line is eligible.
- With no accept and out_ready high, out_valid ← 0.
- frame_start:
  - col and stride counter ← 0, out_valid ← 0;
  - window contents are left unchanged;
  - blocks acceptance in the same cycle;
  - takes priority over every other event.
- Line wrap: the window is not cleared; columns from the previous line are flushed naturally because columns 0..BLOCK_WIDTH-2 never emit.
- Widths: col compares are unsigned COL_WIDTH bits; no arithmetic on pixel data.

## Timing
- Reset values:
  - in_ready = 1 (while frame_start is low);
  - out_valid = 0, out_last = 0, out_col = 0, out_pixels = 0;
  - col = 0, stride counter = 0.
- Latency: a window appears 1 cycle after the accept of its newest column.
- Throughput: 1 column/cycle while out_ready is held high.
- Backpressure: while out_valid && !out_ready, out_pixels, out_col and out_last are held stable and in_ready = 0.
- Simultaneous accept and output handshake in the same cycle: the new window (or out_valid=0) replaces the old one, with no bubble.
- Reset asserted mid-line: all state returns to reset values immediately; no partial window is emitted after release.

## Configuration
- KERNEL_WINDOW_EDGE_REPLICATE_EN undefined:
  - behaviour exactly as above;
  - (IMAGE_WIDTH-BLOCK_WIDTH)/STRIDE+1 windows per line.
- KERNEL_WINDOW_EDGE_REPLICATE_EN defined (left-border replication):
  - an accept at col 0 loads in_pixels into every window column;
  - every col is eligible, with the stride counter reset at col 0;
  - ceil(IMAGE_WIDTH/STRIDE) windows per line;
  - out_last uses the same "no later eligible column" rule.

## Test plan
- BLOCK_WIDTH=3, BLOCK_HEIGHT=3, IMAGE_WIDTH=8, STRIDE=1; feed columns with every pixel equal to its col (0..7), out_ready=1 -> 6 windows:
  - first window has c0..c2 = 0,1,2 and out_col=2;
  - last window is 5,6,7 with out_col=7 and out_last=1.
- Same stimulus with STRIDE=2 -> windows at out_col 2, 4, 6; out_last only at 6.
- Two lines back to back -> the second line's first window appears at its col 2 with contents 0,1,2; no window mixes columns from both lines.
- out_ready low for 5 cycles after the first window -> out_pixels held at 0,1,2 and in_ready=0; on release, the next window 1,2,3 follows with no loss.
- frame_start asserted at col 4, then columns with values 10..12 -> no window before the third new column; that window is 10,11,12 with out_col=2. Reset low at col 5 -> all outputs 0 immediately.
- KERNEL_WINDOW_EDGE_REPLICATE_EN defined, IMAGE_WIDTH=8, STRIDE=1 -> 8 windows; col 0 window is 0,0,0; col 1 window is 0,0,1; col 7 window has out_last=1.
